game_ctrl: RTL and testbench
============================

# game_ctrl

Move sequencer for the tic-tac-toe board register array. It accepts player move requests, checks the target cell through the array's write-port readback, and issues a single-cycle write with the current player's mark. It then samples the win-line flags and pulses `save` on a VGA frame boundary to refresh the display buffer. It also runs the new-game clear sweep and tracks turn, move count and game result.

## Interface
- `FIRST_PLAYER`, default 0: player that moves first after reset or a new game (0 = X, 1 = O).
- `SAVE_ON_FRAME`, default 1: when 1, `save` waits for `frame_tick`; when 0, `save` fires in the first cycle of SAVE.
- `clk` in 1: system clock. All state changes on the posedge.
- `rst` in 1: asynchronous reset, active-low.
- `move_req` in 1: one-cycle request, already debounced.
- `move_addr` in 4: target cell, 0–8, row-major.
- `new_game` in 1: one-cycle request to clear the board.
- `frame_tick` in 1: one-cycle pulse at VGA vertical blank start.
- `wY` in 2: array cell content at `waddr`; combinational.
- `gameover` in 10: array win flags; any nonzero bit means a line is complete.
- `wen` out 1: array write enable.
- `I` out 2: write data. 00 = empty, 01 = X, 10 = O.
- `waddr` out 4: array write/readback address.
- `save` out 1: copy array to the VGA buffer.
- `turn` out 1: player to move (0 = X, 1 = O).
- `move_count` out 4: accepted moves, 0–9.
- `status` out 2: 00 playing, 01 win, 10 draw.
- `winner` out 1: last mover. Valid when `status` = 01.
- `move_ack` out 1: one-cycle pulse, move committed.
- `move_rej` out 1: one-cycle pulse, move refused.
- `busy` out 1: high in every state except IDLE, OVER and DRAW.

## Operation
- States: IDLE, CHECK, WRITE, EVAL, SAVE, OVER, DRAW, CLEAR.
- IDLE
  - `new_game` goes to CLEAR. It has priority over a simultaneous `move_req`.
  - `move_req` with `move_addr` > 8: pulse `move_rej`, stay in IDLE.
  - Otherwise latch `move_addr` into `waddr` and go to CHECK.
- CHECK: if `wY` ≠ 00, pulse `move_rej` and return to IDLE. Otherwise go to WRITE.
- WRITE
  - `wen` = 1 and `I` = {`turn`, ~`turn`} for exactly one cycle.
  - The array commits on the negedge inside this cycle.
- EVAL: sample `gameover` and update the game.
  - `move_count` += 1, `move_ack` = 1, `winner` = `turn`, then toggle `turn`.
  - `gameover` ≠ 0: `status` = 01, next state OVER via SAVE.
  - Else if `move_count` reaches 9: `status` = 10, next state DRAW via SAVE.
  - Else: next state IDLE via SAVE.
- SAVE: assert `save` for one cycle in the cycle where `frame_tick` = 1 (or immediately if `SAVE_ON_FRAME` = 0), then go to the stored next state.
- OVER / DRAW
  - `move_req` pulses `move_rej`.
  - `new_game` goes to CLEAR.
- CLEAR
  - 9 cycles, each with `wen` = 1 and `I` = 00; `waddr` steps 0..8.
  - Then reset the game: `move_count` = 0, `status` = 00, `turn` = `FIRST_PLAYER`.
  - Then go to SAVE with next state IDLE.
  - The first write also triggers the array's own clear-on-gameover. This is harmless.
- `move_req` and `new_game` outside IDLE/OVER/DRAW are dropped with no pulse.
- `move_count` saturates at 9. Width rule: 4-bit unsigned compare with the constant 9.

## Timing
- Accepted move, IDLE to `move_ack`: request seen at posedge n, CHECK at n+1, WRITE at n+2, EVAL at n+3. `move_ack` is high during cycle n+3.
- `save`: no earlier than cycle n+4. With `SAVE_ON_FRAME` = 1 it is unbounded, waiting for `frame_tick`.
- Rejected move: `move_rej` in cycle n+1 (range error) or n+2 (occupied cell).
- Clear sweep: 9 write cycles followed by SAVE.
- Reset values:
  - State IDLE; `turn` = `FIRST_PLAYER`.
  - `wen`, `save`, `move_ack`, `move_rej`, `busy`, `winner` = 0.
  - `I` = 00, `waddr` = 0, `move_count` = 0, `status` = 00.
- Reset asserted mid-WRITE or mid-CLEAR: `wen` drops asynchronously. The array shares the reset net (inverted at top level), so the board also clears. No recovery sweep is needed.
- All outputs are registered except `busy`, which is decoded from state.

## Structure
- Package `ttt_pkg` holds:
  - the state enum;
  - cell codes `CELL_EMPTY` = 00, `CELL_X` = 01, `CELL_O` = 10;
  - `NUM_CELLS` = 9;
  - the status codes.
- Single flat module with no sub-module. The sweep counter reuses the `waddr` register.

## Test plan
- After reset, `move_req` with addr 4: `waddr` = 4, `wen` high one cycle with `I` = 01, `move_ack` at n+3, `turn` = 1, `move_count` = 1. Then `frame_tick`: `save` high one cycle.
- Second move to occupied cell 4: `move_rej` at n+2, no `wen`, `turn` and `move_count` unchanged.
- `move_addr` = 9 or 15: `move_rej` at n+1. `move_req` while `busy`: ignored.
- X plays 0, 1, 2 (O plays 3, 4): `gameover` nonzero at EVAL, `status` = 01, `winner` = 0, state OVER. A further `move_req` gives `move_rej`.
- Draw sequence 0,1,2,4,3,5,7,6,8: `move_count` = 9, `status` = 10. Then `new_game`: 9 `wen` cycles with `I` = 00 and `waddr` 0..8, then `save`, `status` = 00, `turn` = `FIRST_PLAYER`.
- Reset pulled low during CLEAR: all outputs return to reset values immediately.
- Simultaneous `new_game` and `move_req` in IDLE: enters CLEAR, no `move_ack` or `move_rej`.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer.
package ttt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE,
    ST_EVAL,
    ST_SAVE,
    ST_OVER,
    ST_DRAW,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    STATUS_PLAY = 2'b00,
    STATUS_WIN  = 2'b01,
    STATUS_DRAW = 2'b10
  } status_t;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam int         NUM_CELLS = 9;
  localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);
  localparam logic [3:0] MAX_MOVES = 4'(NUM_CELLS);

endpackage

// File: rtl/game_ctrl.sv
// Move sequencer for the tic-tac-toe board register array: validates and commits
// moves, evaluates the game, runs the clear sweep and requests display refreshes.
module game_ctrl
  import ttt_pkg::*;
#(
  parameter bit FIRST_PLAYER  = 1'b0,
  parameter bit SAVE_ON_FRAME = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_req,
  input  logic [3:0] move_addr,
  input  logic       new_game,
  input  logic       frame_tick,
  input  logic [1:0] wY,
  input  logic [9:0] gameover,
  output logic       wen,
  output logic [1:0] I,
  output logic [3:0] waddr,
  output logic       save,
  output logic       turn,
  output logic [3:0] move_count,
  output logic [1:0] status,
  output logic       winner,
  output logic       move_ack,
  output logic       move_rej,
  output logic       busy
);

  state_t     state, state_d;
  state_t     ret_state, ret_state_d;
  logic       wen_d, save_d, turn_d, winner_d, move_ack_d, move_rej_d;
  logic [1:0] i_d, status_d;
  logic [3:0] waddr_d, move_count_d;

  assign busy = !(state inside {ST_IDLE, ST_OVER, ST_DRAW});

  // NOTE: every target gets a default before the case, so no path can leave a
  // value unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    ret_state_d  = ret_state;
    wen_d        = 1'b0;
    i_d          = CELL_EMPTY;
    waddr_d      = waddr;
    save_d       = 1'b0;
    turn_d       = turn;
    move_count_d = move_count;
    status_d     = status;
    winner_d     = winner;
    move_ack_d   = 1'b0;
    move_rej_d   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (new_game) begin
          state_d = ST_CLEAR;
          wen_d   = 1'b1;
          waddr_d = '0;
        end else if (move_req) begin
          if (move_addr > LAST_CELL) begin
            move_rej_d = 1'b1;
          end else begin
            waddr_d = move_addr;
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (wY != CELL_EMPTY) begin
          move_rej_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          wen_d   = 1'b1;
          i_d     = {turn, ~turn};
          state_d = ST_WRITE;
        end
      end

      // Move bookkeeping is registered on entry to EVAL so that move_ack,
      // turn and move_count are already visible during the EVAL cycle.
      ST_WRITE: begin
        move_ack_d = 1'b1;
        winner_d   = turn;
        turn_d     = ~turn;
        if (move_count != MAX_MOVES) move_count_d = move_count + 4'd1;
        state_d = ST_EVAL;
      end

      ST_EVAL: begin
        state_d = ST_SAVE;
        save_d  = !SAVE_ON_FRAME;
        if (|gameover) begin
          status_d    = STATUS_WIN;
          ret_state_d = ST_OVER;
        end else if (move_count == MAX_MOVES) begin
          status_d    = STATUS_DRAW;
          ret_state_d = ST_DRAW;
        end else begin
          ret_state_d = ST_IDLE;
        end
      end

      // Without frame sync the pulse was already issued on entry.
      ST_SAVE: begin
        if (!SAVE_ON_FRAME || frame_tick) begin
          save_d  = SAVE_ON_FRAME && frame_tick;
          state_d = ret_state;
        end
      end

      ST_OVER, ST_DRAW: begin
        if (new_game) begin
          state_d = ST_CLEAR;
          wen_d   = 1'b1;
          waddr_d = '0;
        end else if (move_req) begin
          move_rej_d = 1'b1;
        end
      end

      // waddr doubles as the sweep counter.
      ST_CLEAR: begin
        if (waddr == LAST_CELL) begin
          move_count_d = '0;
          status_d     = STATUS_PLAY;
          turn_d       = FIRST_PLAYER;
          ret_state_d  = ST_IDLE;
          state_d      = ST_SAVE;
          save_d       = !SAVE_ON_FRAME;
        end else begin
          wen_d   = 1'b1;
          waddr_d = waddr + 4'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values computed before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ret_state  <= ST_IDLE;
      wen        <= 1'b0;
      I          <= CELL_EMPTY;
      waddr      <= '0;
      save       <= 1'b0;
      turn       <= FIRST_PLAYER;
      move_count <= '0;
      status     <= STATUS_PLAY;
      winner     <= 1'b0;
      move_ack   <= 1'b0;
      move_rej   <= 1'b0;
    end else begin
      state      <= state_d;
      ret_state  <= ret_state_d;
      wen        <= wen_d;
      I          <= i_d;
      waddr      <= waddr_d;
      save       <= save_d;
      turn       <= turn_d;
      move_count <= move_count_d;
      status     <= status_d;
      winner     <= winner_d;
      move_ack   <= move_ack_d;
      move_rej   <= move_rej_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: emulated board array plus a game-rules model.
module tb_game_ctrl;
  import ttt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_req = 1'b0;
  logic [3:0] move_addr = '0;
  logic       new_game = 1'b0;
  logic       frame_tick = 1'b0;
  logic [1:0] wY;
  logic [9:0] gameover;
  logic       wen, save, turn, winner, move_ack, move_rej, busy;
  logic [1:0] I, status;
  logic [3:0] waddr, move_count;

  game_ctrl dut (
    .clk(clk), .rst(rst), .move_req(move_req), .move_addr(move_addr),
    .new_game(new_game), .frame_tick(frame_tick), .wY(wY), .gameover(gameover),
    .wen(wen), .I(I), .waddr(waddr), .save(save), .turn(turn),
    .move_count(move_count), .status(status), .winner(winner),
    .move_ack(move_ack), .move_rej(move_rej), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                  '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [7:0] line_flags(input logic [8:0][1:0] b);
    logic [7:0] f;
    for (int l = 0; l < 8; l++) begin
      f[l] = (b[LINES[l][0]] != 2'b00) && (b[LINES[l][0]] == b[LINES[l][1]]) &&
             (b[LINES[l][0]] == b[LINES[l][2]]);
    end
    return f;
  endfunction

  // Board register array: writes on the negedge, cleared by the shared reset.
  logic [8:0][1:0] arr;
  always @(negedge clk or negedge rst) begin
    if (!rst) arr <= '0;
    else if (wen && waddr < 4'd9) arr[waddr] <= I;
  end
  assign wY = (waddr < 4'd9) ? arr[waddr] : 2'b00;
  always_comb gameover = {2'b00, line_flags(arr)};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Game-rules model
  logic [8:0][1:0] mboard;
  logic            m_turn, m_winner;
  int              m_count;
  logic [1:0]      m_status;

  task automatic model_new_game();
    mboard   = '0;
    m_turn   = 1'b0;
    m_count  = 0;
    m_status = 2'b00;
  endtask

  task automatic frame_save(input bit poke);
    int cnt;
    check("save_early", save, 0);
    check("busy_save", busy, 1);
    move_req  = poke;
    move_addr = 4'd0;
    tick();
    move_req = 1'b0;
    check("drop_ack", move_ack, 0);
    check("drop_rej", move_rej, 0);
    check("save_wait", save, 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    cnt = save;
    tick();
    cnt += save;
    tick();
    cnt += save;
    check("save_pulses", cnt, 1);
    check("busy_after_save", busy, 0);
  endtask

  task automatic do_move(input int addr);
    logic [1:0] mark;
    move_addr = 4'(addr);
    move_req  = 1'b1;
    tick();
    move_req = 1'b0;
    if (m_status != 2'b00 || addr > 8) begin
      check("rej_now", move_rej, 1);
      check("rej_no_ack", move_ack, 0);
      check("rej_no_wen", wen, 0);
      tick();
      check("rej_pulse_end", move_rej, 0);
      check("rej_turn", turn, m_turn);
      check("rej_count", move_count, m_count);
    end else if (mboard[addr] != 2'b00) begin
      check("occ_n1_rej", move_rej, 0);
      check("occ_busy", busy, 1);
      tick();
      check("occ_rej", move_rej, 1);
      check("occ_no_wen", wen, 0);
      tick();
      check("occ_turn", turn, m_turn);
      check("occ_count", move_count, m_count);
      check("occ_idle", busy, 0);
    end else begin
      mark = m_turn ? 2'b10 : 2'b01;
      check("chk_no_wen", wen, 0);
      tick();
      check("wr_wen", wen, 1);
      check("wr_data", I, mark);
      check("wr_addr", waddr, addr);
      tick();
      mboard[addr] = mark;
      m_count++;
      m_winner = m_turn;
      m_turn   = ~m_turn;
      if (line_flags(mboard) != 0) m_status = 2'b01;
      else if (m_count == 9) m_status = 2'b10;
      check("ack", move_ack, 1);
      check("ack_no_wen", wen, 0);
      check("ack_turn", turn, m_turn);
      check("ack_count", move_count, m_count);
      check("board_cell", arr[addr], mark);
      tick();
      check("ack_end", move_ack, 0);
      check("status", status, m_status);
      if (m_status == 2'b01) check("winner", winner, m_winner);
      frame_save($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic new_game_seq(input bit with_move);
    new_game  = 1'b1;
    move_req  = with_move;
    move_addr = 4'd2;
    tick();
    new_game = 1'b0;
    move_req = 1'b0;
    check("clr_no_rej", move_rej, 0);
    check("clr_no_ack", move_ack, 0);
    for (int k = 0; k < 9; k++) begin
      check("clr_wen", wen, 1);
      check("clr_data", I, 0);
      check("clr_addr", waddr, k);
      tick();
    end
    check("clr_done_wen", wen, 0);
    model_new_game();
    check("clr_status", status, m_status);
    check("clr_count", move_count, m_count);
    check("clr_turn", turn, m_turn);
    frame_save(1'b0);
    check("clr_board", arr, 0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_wen"}, wen, 0);
    check({pfx, "_save"}, save, 0);
    check({pfx, "_ack"}, move_ack, 0);
    check({pfx, "_rej"}, move_rej, 0);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_winner"}, winner, 0);
    check({pfx, "_I"}, I, 0);
    check({pfx, "_waddr"}, waddr, 0);
    check({pfx, "_count"}, move_count, 0);
    check({pfx, "_status"}, status, 0);
    check({pfx, "_turn"}, turn, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int steps;
    int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int win_seq [5]  = '{0, 3, 1, 4, 2};

    model_new_game();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    do_move(4);
    do_move(4);
    do_move(9);
    do_move(15);

    new_game_seq(1'b0);
    foreach (win_seq[i]) do_move(win_seq[i]);
    check("win_busy", busy, 0);
    do_move(5);

    new_game_seq(1'b0);
    foreach (draw_seq[i]) do_move(draw_seq[i]);
    check("draw_count", move_count, 9);
    do_move(0);

    new_game_seq(1'b0);
    new_game_seq(1'b1);

    for (int g = 0; g < 8; g++) begin
      steps = 0;
      while (m_status == 2'b00 && steps < 30) begin
        do_move($urandom_range(0, 11));
        steps++;
      end
      do_move($urandom_range(0, 8));
      new_game_seq($urandom_range(0, 1) == 1);
    end

    // Asynchronous reset in the middle of the clear sweep.
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
    tick();
    check("pre_rst_wen", wen, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async");
    check("async_board", arr, 0);
    @(negedge clk);
    rst = 1'b1;
    model_new_game();
    tick();
    do_move(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
